step_lane_sequencer: RTL and testbench
======================================

Name: step_lane_sequencer

Overview:
Parametrised successor to the fixed 4-lane step register, column muxer and scoring path of the dance-game top level. It takes arrow patterns into a LANES x DEPTH scrolling field on each beat and scans the field onto a column-multiplexed LED matrix. Button presses are judged against the bottom (judgement) row, with hit/miss pulses, a combo counter and a saturating score. It sits between the beat source and pattern source on one side, and the LED matrix and score display on the other.

Parameters:
LANES, 4, number of arrow lanes (>=2), one matrix column per lane
DEPTH, 8, rows per lane (>=2); row DEPTH-1 is the judgement row
SCAN_BITS, 16, free-running scan counter width; lane index advances on each counter wrap
SCORE_W, 9, score width
COMBO_BONUS, 8, combo value at or above which a hit scores 2 instead of 1
PENALIZE_EMPTY, 1, 1 = a press on a lane with an empty judgement row counts as a miss

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
beat  in  1  beat level (bpm clock), asynchronous to clk
step_in  in  LANES  arrow pattern loaded into row 0 on each beat
button  in  LANES  raw button levels, asynchronous, active-high
col_en_n  out  LANES  active-low one-hot column (lane) enable
col  out  DEPTH  row bits of the enabled lane; col[i] = row i
hit_pulse  out  1  one-cycle pulse, at least one hit this cycle
miss_pulse  out  1  one-cycle pulse, at least one miss this cycle
green_led  out  1  high after the latest judgement was a hit
red_led  out  1  high after the latest judgement was a miss
combo  out  8  consecutive-hit count, saturates at 255
score  out  SCORE_W  accumulated score, saturating at both ends

Behaviour:
- Reset (async, immediate): all field bits, sync flops, counters, combo and score = 0. Lane index = 0, so col_en_n = ~1 (only bit 0 low) and col = 0. hit_pulse, miss_pulse, green_led and red_led = 0. Reset mid-scroll discards the whole field.
- beat and each button bit: 2-flop synchroniser, then a third flop for rising-edge detect.
  - step_en is a 1-cycle pulse per beat rising edge.
  - press[l] is a 1-cycle pulse per button rising edge.
  - A held level never retriggers.
- Shift on step_en, per lane:
  - row[DEPTH-1] is judged, then row[i] <= row[i-1].
  - row[0] <= step_in[l], sampled on the step_en cycle.
- Judgement, all lanes evaluated in the same cycle:
  - Hit: press[l] with row[DEPTH-1][l] = 1. That bit is cleared, even if step_en coincides; the hit wins and the arrow is not counted as missed.
  - Miss: step_en with row[DEPTH-1][l] = 1 and no press on that lane that cycle (the arrow scrolled off).
  - Miss: press[l] with row[DEPTH-1][l] = 0, only when PENALIZE_EMPTY = 1.
  - H = number of hit lanes and M = number of miss lanes this cycle; each is clog2(LANES+1) bits.
- Combo, registered:
  - M > 0: combo <= min(H, 255).
  - M = 0: combo <= min(combo + H, 255).
- Score, registered, computed in a signed intermediate of SCORE_W+clog2(LANES)+3 bits:
  - Per-hit value is 2 if the pre-update combo >= COMBO_BONUS, else 1.
  - score <= clamp(score + H*value - M, 0, 2^SCORE_W-1).
- Judgement outputs:
  - hit_pulse = (H > 0) and miss_pulse = (M > 0), registered, in the same cycle as the combo/score update.
  - green_led <= 1 and red_led <= 0 when H > 0 and M = 0.
  - red_led <= 1 and green_led <= 0 when M > 0; miss dominates.
  - Both LEDs hold otherwise.
- Latency:
  - A button rising edge sampled at clk edge k gives hit_pulse/miss_pulse and the updated score/combo after edge k+3.
  - A beat edge sampled at edge k gives the shifted field after edge k+3.
- Scan:
  - The SCAN_BITS counter is free-running and wraps.
  - On the wrap cycle the lane index advances 0, 1, ..., LANES-1, 0.
  - col_en_n and col are registered from the index and the field, so col reflects field changes within 1 cycle.
- All arithmetic is unsigned except the score intermediate. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset, LANES=4, DEPTH=8: step_in=0001 on one beat, then 7 more beats with step_in=0; press lane 0 -> hit_pulse one cycle, score=1, combo=1, green_led=1, row 7 lane 0 cleared.
- Same arrow, no press, one extra beat -> miss_pulse, combo=0, score stays 0 (floor clamp), red_led=1.
- step_in=0110 then 7 beats; press lanes 1 and 2 in the same cycle -> H=2, score +2, combo +2, a single hit_pulse.
- Build combo to 8 with 8 single hits (score=8); 9th hit -> score=10. Then an empty-lane press -> score=9, combo=0, red_led=1.
- Press on a lane in the same cycle as step_en, with that lane's row 7 set -> hit, no miss. Score increments once, and row 7 takes row 6.
- SCAN_BITS=4: col_en_n cycles 1110 -> 1101 -> 1011 -> 0111 every 16 clks, and col matches each lane's rows. Assert reset mid-scan -> col_en_n=1110, col=0, score=0 immediately.

Source files
------------

// File: rtl/step_lane_sequencer.sv
// step_lane_sequencer: LANES x DEPTH scrolling arrow field with beat-driven
// shifting, button judgement on the bottom row, combo/score tracking and a
// column-multiplexed LED matrix scan.

// One arrow lane: button synchroniser and edge detect, the lane's row shift
// register, and this lane's hit/miss decision for the current cycle.
module step_lane #(
    parameter int DEPTH          = 8,
    parameter int PENALIZE_EMPTY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button,
    input  logic             step_en,
    input  logic             step_bit,
    output logic [DEPTH-1:0] rows,
    output logic             hit,
    output logic             miss
);
    logic [2:0] btn_sync;
    logic       press;

    // Two flops against metastability, a third remembers the previous level;
    // the edge is registered so a press lands in the same cycle as step_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_sync <= '0;
            press    <= 1'b0;
        end else begin
            btn_sync <= {btn_sync[1:0], button};
            press    <= btn_sync[1] & ~btn_sync[2];
        end
    end

    // A press on a lit judgement row always wins over the arrow scrolling off.
    assign hit  = press & rows[DEPTH-1];
    assign miss = (step_en & rows[DEPTH-1] & ~press) |
                  (press & ~rows[DEPTH-1] & (PENALIZE_EMPTY != 0));

    // Shift on the beat; otherwise a hit consumes the judgement-row arrow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rows <= '0;
        else if (step_en)
            rows <= {rows[DEPTH-2:0], step_bit};
        else if (hit)
            rows[DEPTH-1] <= 1'b0;
    end
endmodule

module step_lane_sequencer #(
    parameter int LANES          = 4,
    parameter int DEPTH          = 8,
    parameter int SCAN_BITS      = 16,
    parameter int SCORE_W        = 9,
    parameter int COMBO_BONUS    = 8,
    parameter int PENALIZE_EMPTY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               beat,
    input  logic [LANES-1:0]   step_in,
    input  logic [LANES-1:0]   button,
    output logic [LANES-1:0]   col_en_n,
    output logic [DEPTH-1:0]   col,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               green_led,
    output logic               red_led,
    output logic [7:0]         combo,
    output logic [SCORE_W-1:0] score
);
    localparam int HW = $clog2(LANES + 1);
    localparam int IW = $clog2(LANES);
    localparam int SW = SCORE_W + $clog2(LANES) + 3;
    localparam int CW = (HW > 8) ? HW + 1 : 9;
    localparam logic signed [SW-1:0] SMAX = {{(SW-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

    logic [2:0]                       beat_sync;
    logic                             step_en;
    logic [LANES-1:0][DEPTH-1:0]      rows;
    logic [LANES-1:0]                 lane_hit, lane_miss;
    logic [HW-1:0]                    h_cnt, m_cnt;
    logic                             bonus;
    logic [SW-1:0]                    pts;
    logic signed [SW-1:0]             acc;
    logic [SCORE_W-1:0]               score_nx;
    logic [CW-1:0]                    csum;
    logic [7:0]                       combo_nx;
    logic [SCAN_BITS-1:0]             scan_cnt;
    logic [IW-1:0]                    lane_idx;

    // Beat synchroniser with registered rising-edge pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_sync <= '0;
            step_en   <= 1'b0;
        end else begin
            beat_sync <= {beat_sync[1:0], beat};
            step_en   <= beat_sync[1] & ~beat_sync[2];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        step_lane #(.DEPTH(DEPTH), .PENALIZE_EMPTY(PENALIZE_EMPTY)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .button   (button[l]),
            .step_en  (step_en),
            .step_bit (step_in[l]),
            .rows     (rows[l]),
            .hit      (lane_hit[l]),
            .miss     (lane_miss[l])
        );
    end

    // Count hit and miss lanes for this cycle.
    always_comb begin
        h_cnt = '0;
        m_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            h_cnt = h_cnt + HW'(lane_hit[l]);
            m_cnt = m_cnt + HW'(lane_miss[l]);
        end
    end

    // Next score and combo; score math is signed so misses can clamp at zero.
    always_comb begin
        bonus = {24'd0, combo} >= 32'(COMBO_BONUS);
        pts   = bonus ? (SW'(h_cnt) << 1) : SW'(h_cnt);
        acc   = $signed(SW'(score)) + $signed(pts) - $signed(SW'(m_cnt));
        if (acc < 0)
            score_nx = '0;
        else if (acc > SMAX)
            score_nx = '1;
        else
            score_nx = acc[SCORE_W-1:0];

        csum = CW'(combo) + CW'(h_cnt);
        if (m_cnt != '0)
            combo_nx = (CW'(h_cnt) > CW'(255)) ? 8'hff : 8'(h_cnt);
        else
            combo_nx = (csum > CW'(255)) ? 8'hff : 8'(csum);
    end

    // Register judgement results; a miss takes the LEDs over any hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            green_led  <= 1'b0;
            red_led    <= 1'b0;
            combo      <= '0;
            score      <= '0;
        end else begin
            hit_pulse  <= (h_cnt != '0);
            miss_pulse <= (m_cnt != '0);
            combo      <= combo_nx;
            score      <= score_nx;
            if (m_cnt != '0) begin
                red_led   <= 1'b1;
                green_led <= 1'b0;
            end else if (h_cnt != '0) begin
                green_led <= 1'b1;
                red_led   <= 1'b0;
            end
        end
    end

    // Free-running scan; the lane index steps once per counter wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            lane_idx <= '0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_BITS'(1);
            if (&scan_cnt)
                lane_idx <= (lane_idx == IW'(LANES - 1)) ? '0 : lane_idx + IW'(1);
        end
    end

    // Matrix drive registered from the index and the live field.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_en_n <= ~LANES'(1);
            col      <= '0;
        end else begin
            col_en_n <= ~(LANES'(1) << lane_idx);
            col      <= rows[lane_idx];
        end
    end
endmodule

// File: tb/tb_step_lane_sequencer.sv
// Directed bench for step_lane_sequencer (LANES=4, DEPTH=8, SCAN_BITS=4).
module tb_step_lane_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       beat = 1'b0;
    logic [3:0] step_in = '0;
    logic [3:0] button = '0;
    logic [3:0] col_en_n;
    logic [7:0] col;
    logic       hit_pulse, miss_pulse, green_led, red_led;
    logic [7:0] combo;
    logic [8:0] score;

    int n_cmp = 0;
    int n_bad = 0;
    int hc, mc, first;

    step_lane_sequencer #(
        .LANES(4), .DEPTH(8), .SCAN_BITS(4), .SCORE_W(9),
        .COMBO_BONUS(8), .PENALIZE_EMPTY(1)
    ) dut (
        .clk(clk), .reset(reset), .beat(beat), .step_in(step_in), .button(button),
        .col_en_n(col_en_n), .col(col), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .green_led(green_led), .red_led(red_led), .combo(combo), .score(score)
    );

    always #5 clk = ~clk;

    // Count judgement pulses over n negedges, noting the first pulse position.
    task automatic watch(input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (hit_pulse) begin hc++; if (first < 0) first = i; end
            if (miss_pulse) begin mc++; if (first < 0) first = i; end
        end
    endtask

    task automatic stim(input logic [3:0] btn, input logic [3:0] pat, input logic b);
        hc = 0; mc = 0; first = -1;
        button = btn; step_in = pat; beat = b;
        watch(4);
        button = '0; step_in = '0; beat = 1'b0;
        watch(4);
    endtask

    task automatic do_beat(input logic [3:0] pat);
        stim(4'b0000, pat, 1'b1);
    endtask

    task automatic press(input logic [3:0] m);
        stim(m, 4'b0000, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_cmp++; if (col_en_n !== 4'b1110) begin n_bad++; $display("FAIL rst_col_en_n got %b want 1110", col_en_n); end
        n_cmp++; if (col !== 8'h00) begin n_bad++; $display("FAIL rst_col got %h want 00", col); end
        n_cmp++; if ({hit_pulse, miss_pulse, green_led, red_led} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got %b want 0000", {hit_pulse, miss_pulse, green_led, red_led}); end
        n_cmp++; if (score !== 9'd0 || combo !== 8'd0) begin n_bad++; $display("FAIL rst_score got %0d/%0d want 0/0", score, combo); end
        reset = 1'b0;
    endtask

    task automatic test_hit();
        do_beat(4'b0001);
        for (int i = 0; i < 7; i++) do_beat(4'b0000);
        press(4'b0001);
        n_cmp++; if (hc !== 1 || mc !== 0) begin n_bad++; $display("FAIL hit_pulses got h%0d m%0d want h1 m0", hc, mc); end
        n_cmp++; if (first !== 4) begin n_bad++; $display("FAIL hit_latency got %0d want 4", first); end
        n_cmp++; if (score !== 9'd1 || combo !== 8'd1) begin n_bad++; $display("FAIL hit_score got %0d/%0d want 1/1", score, combo); end
        n_cmp++; if (green_led !== 1'b1 || red_led !== 1'b0) begin n_bad++; $display("FAIL hit_leds got g%b r%b want g1 r0", green_led, red_led); end
        // the consumed arrow must not come back as a miss
        do_beat(4'b0000);
        n_cmp++; if (mc !== 0) begin n_bad++; $display("FAIL hit_cleared got miss %0d want 0", mc); end
    endtask

    task automatic test_miss();
        do_reset();
        do_beat(4'b0001);
        for (int i = 0; i < 7; i++) do_beat(4'b0000);
        do_beat(4'b0000);
        n_cmp++; if (mc !== 1 || hc !== 0 || first !== 4) begin n_bad++; $display("FAIL miss_pulse got m%0d h%0d at %0d want m1 h0 at 4", mc, hc, first); end
        n_cmp++; if (score !== 9'd0 || combo !== 8'd0) begin n_bad++; $display("FAIL miss_floor got %0d/%0d want 0/0", score, combo); end
        n_cmp++; if (red_led !== 1'b1 || green_led !== 1'b0) begin n_bad++; $display("FAIL miss_leds got g%b r%b want g0 r1", green_led, red_led); end
    endtask

    task automatic test_multi();
        do_beat(4'b0110);
        for (int i = 0; i < 7; i++) do_beat(4'b0000);
        press(4'b0110);
        n_cmp++; if (hc !== 1 || mc !== 0) begin n_bad++; $display("FAIL multi_pulses got h%0d m%0d want h1 m0", hc, mc); end
        n_cmp++; if (score !== 9'd2 || combo !== 8'd2) begin n_bad++; $display("FAIL multi_score got %0d/%0d want 2/2", score, combo); end
        n_cmp++; if (green_led !== 1'b1 || red_led !== 1'b0) begin n_bad++; $display("FAIL multi_leds got g%b r%b want g1 r0", green_led, red_led); end
    endtask

    task automatic test_bonus();
        do_reset();
        for (int i = 0; i < 8; i++) do_beat(4'b0001);
        for (int j = 1; j <= 9; j++) begin
            press(4'b0001);
            if (j == 8) begin
                n_cmp++; if (score !== 9'd8 || combo !== 8'd8) begin n_bad++; $display("FAIL bonus_8 got %0d/%0d want 8/8", score, combo); end
            end
            if (j < 9) do_beat((j == 1) ? 4'b0001 : 4'b0000);
        end
        n_cmp++; if (score !== 9'd10 || combo !== 8'd9) begin n_bad++; $display("FAIL bonus_9 got %0d/%0d want 10/9", score, combo); end
        press(4'b0010);
        n_cmp++; if (mc !== 1 || hc !== 0) begin n_bad++; $display("FAIL empty_pulses got h%0d m%0d want h0 m1", hc, mc); end
        n_cmp++; if (score !== 9'd9 || combo !== 8'd0) begin n_bad++; $display("FAIL empty_score got %0d/%0d want 9/0", score, combo); end
        n_cmp++; if (red_led !== 1'b1 || green_led !== 1'b0) begin n_bad++; $display("FAIL empty_leds got g%b r%b want g0 r1", green_led, red_led); end
    endtask

    task automatic test_coincident();
        do_beat(4'b0100);
        do_beat(4'b0100);
        for (int i = 0; i < 6; i++) do_beat(4'b0000);
        stim(4'b0100, 4'b0000, 1'b1);
        n_cmp++; if (hc !== 1 || mc !== 0) begin n_bad++; $display("FAIL coin_pulses got h%0d m%0d want h1 m0", hc, mc); end
        n_cmp++; if (score !== 9'd10 || combo !== 8'd1) begin n_bad++; $display("FAIL coin_score got %0d/%0d want 10/1", score, combo); end
        // the second arrow shifted into the judgement row
        press(4'b0100);
        n_cmp++; if (hc !== 1 || mc !== 0) begin n_bad++; $display("FAIL coin_row6 got h%0d m%0d want h1 m0", hc, mc); end
        n_cmp++; if (score !== 9'd11 || combo !== 8'd2) begin n_bad++; $display("FAIL coin_score2 got %0d/%0d want 11/2", score, combo); end
    endtask

    task automatic test_mixed();
        do_beat(4'b0001);
        for (int i = 0; i < 7; i++) do_beat(4'b0000);
        press(4'b0111);
        n_cmp++; if (hc !== 1 || mc !== 1) begin n_bad++; $display("FAIL mixed_pulses got h%0d m%0d want h1 m1", hc, mc); end
        n_cmp++; if (score !== 9'd10 || combo !== 8'd1) begin n_bad++; $display("FAIL mixed_score got %0d/%0d want 10/1", score, combo); end
        n_cmp++; if (red_led !== 1'b1 || green_led !== 1'b0) begin n_bad++; $display("FAIL mixed_leds got g%b r%b want g0 r1", green_led, red_led); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_en [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        logic [7:0] exp_col [4] = '{8'h02, 8'h01, 8'h01, 8'h04};
        logic [3:0] prev;
        int t;
        do_beat(4'b0001);
        do_beat(4'b0010);
        do_beat(4'b1100);
        t = 0;
        while (col_en_n !== 4'b1110 && t < 100) begin @(negedge clk); t++; end
        n_cmp++; if (col_en_n !== 4'b1110) begin n_bad++; $display("FAIL scan_align got %b want 1110", col_en_n); end
        n_cmp++; if (col !== 8'h04) begin n_bad++; $display("FAIL scan_col0 got %h want 04", col); end
        for (int k = 0; k < 4; k++) begin
            prev = col_en_n;
            t = 0;
            while (col_en_n === prev && t < 40) begin @(negedge clk); t++; end
            n_cmp++; if (col_en_n !== exp_en[k]) begin n_bad++; $display("FAIL scan_en%0d got %b want %b", k, col_en_n, exp_en[k]); end
            n_cmp++; if (col !== exp_col[k]) begin n_bad++; $display("FAIL scan_col%0d got %h want %h", k, col, exp_col[k]); end
            if (k > 0) begin
                n_cmp++; if (t !== 16) begin n_bad++; $display("FAIL scan_period%0d got %0d want 16", k, t); end
            end
        end
        n_cmp++; if (score !== 9'd10) begin n_bad++; $display("FAIL scan_pre_score got %0d want 10", score); end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (col_en_n !== 4'b1110 || col !== 8'h00) begin n_bad++; $display("FAIL async_rst_col got %b/%h want 1110/00", col_en_n, col); end
        n_cmp++; if (score !== 9'd0 || combo !== 8'd0) begin n_bad++; $display("FAIL async_rst_score got %0d/%0d want 0/0", score, combo); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_multi();
        test_bonus();
        test_coincident();
        test_mixed();
        test_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
